// File: rtl/reg_file_bp_pkg.sv
// Shared register-file constants used by decode and hazard logic.
package reg_file_bp_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned ADDR_W_DEF = 5;
   localparam int unsigned ZERO_REG   = 0;

endpackage : reg_file_bp_pkg

// File: rtl/reg_file_bp_if.sv
// Writeback, read-port and scoreboard signals of the register file.
interface reg_file_bp_if #(
   parameter int unsigned DATA_W = reg_file_bp_pkg::DATA_W_DEF,
   parameter int unsigned ADDR_W = reg_file_bp_pkg::ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2
);

   logic                       we;
   logic [ADDR_W-1:0]          wr_addr;
   logic [DATA_W-1:0]          wr_data;
   logic [NUM_RD*ADDR_W-1:0]   rd_addr;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_busy;
   logic                       busy_set;
   logic [ADDR_W-1:0]          busy_addr;
   logic [ADDR_W:0]            busy_cnt;

   modport master (
      output we, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
      input  rd_data, rd_busy, busy_cnt
   );

   modport slave (
      input  we, wr_addr, wr_data, rd_addr, busy_set, busy_addr,
      output rd_data, rd_busy, busy_cnt
   );

endinterface : reg_file_bp_if

// File: rtl/reg_scoreboard.sv
// Per-register busy bits with set-over-clear priority and a registered busy count.
module reg_scoreboard
   import reg_file_bp_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   busy_set,
   input  logic [ADDR_W-1:0]      busy_addr,
   input  logic                   we,
   input  logic [ADDR_W-1:0]      wr_addr,
   output logic [(1<<ADDR_W)-1:0] busy,
   output logic [ADDR_W:0]        busy_cnt
);

   localparam int unsigned DEPTH = 1 << ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   logic             set_valid;
   logic             set_eff;
   logic             clr_eff;
   logic [DEPTH-1:0] busy_nxt;
   logic [CNT_W-1:0] cnt_nxt;

   // Next busy vector and count; a set of the same register overrides a clear.
   always_comb begin
      set_valid = busy_set && (busy_addr != ADDR_W'(ZERO_REG));
      set_eff   = set_valid && !busy[busy_addr];
      clr_eff   = we && busy[wr_addr] && !(set_valid && (busy_addr == wr_addr));
      busy_nxt  = busy;
      if (we) begin
         busy_nxt[wr_addr] = 1'b0;
      end
      if (set_valid) begin
         busy_nxt[busy_addr] = 1'b1;
      end
      cnt_nxt = busy_cnt + CNT_W'(set_eff) - CNT_W'(clr_eff);
   end

   // Busy state and count registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy     <= busy_nxt;
         busy_cnt <= cnt_nxt;
      end
   end

endmodule : reg_scoreboard

// File: rtl/reg_file_bp.sv
// Register file with zero register, bypassed combinational read ports and busy scoreboard.
module reg_file_bp
   import reg_file_bp_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned ADDR_W = ADDR_W_DEF,
   parameter int unsigned NUM_RD = 2
) (
   input logic          clk,
   input logic          rst,
   reg_file_bp_if.slave bus
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0]        regs [DEPTH];
   logic [DEPTH-1:0]         busy;
   logic [ADDR_W:0]          busy_cnt;
   logic                     wr_en;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;

   assign wr_en = bus.we && (bus.wr_addr != ADDR_W'(ZERO_REG));

   // Storage array; writes to the zero register are dropped.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned r = 0; r < DEPTH; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_en) begin
         regs[bus.wr_addr] <= bus.wr_data;
      end
   end

   reg_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .busy_set  (bus.busy_set),
      .busy_addr (bus.busy_addr),
      .we        (bus.we),
      .wr_addr   (bus.wr_addr),
      .busy      (busy),
      .busy_cnt  (busy_cnt)
   );

   // One read mux per port: zero register, then same-cycle write bypass, then storage.
   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              nz;
      logic              hit;
      assign ra  = bus.rd_addr[i*ADDR_W +: ADDR_W];
      assign nz  = (ra != ADDR_W'(ZERO_REG));
      assign hit = bus.we && (bus.wr_addr == ra);
      assign rd_data_c[i*DATA_W +: DATA_W] = !nz ? '0 : (hit ? bus.wr_data : regs[ra]);
      assign rd_busy_c[i] = nz && !hit && busy[ra];
   end

   assign bus.rd_data  = rd_data_c;
   assign bus.rd_busy  = rd_busy_c;
   assign bus.busy_cnt = busy_cnt;

endmodule : reg_file_bp

// File: tb/tb_reg_file_bp.sv
// Scoreboard bench: default instance (32/5/2) plus a small sweep instance (16/3/3).
module tb_reg_file_bp;

   typedef struct {
      int          inst;
      int          kind;   // 0 rd_data, 1 rd_busy, 2 busy_cnt
      int          port;
      logic [31:0] exp;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_file_bp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bif ();
   reg_file_bp_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) sif ();

   reg_file_bp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) dut (
      .clk (clk), .rst (rst), .bus (bif)
   );
   reg_file_bp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) dut_s (
      .clk (clk), .rst (rst), .bus (sif)
   );

   // Stimulus state per instance
   bit          s_we [2];
   int          s_wa [2];
   logic [31:0] s_wd [2];
   int          s_ra [2][4];
   bit          s_bs [2];
   int          s_ba [2];

   assign bif.we        = s_we[0];
   assign bif.wr_addr   = 5'(s_wa[0]);
   assign bif.wr_data   = s_wd[0];
   assign bif.rd_addr   = {5'(s_ra[0][1]), 5'(s_ra[0][0])};
   assign bif.busy_set  = s_bs[0];
   assign bif.busy_addr = 5'(s_ba[0]);

   assign sif.we        = s_we[1];
   assign sif.wr_addr   = 3'(s_wa[1]);
   assign sif.wr_data   = 16'(s_wd[1]);
   assign sif.rd_addr   = {3'(s_ra[1][2]), 3'(s_ra[1][1]), 3'(s_ra[1][0])};
   assign sif.busy_set  = s_bs[1];
   assign sif.busy_addr = 3'(s_ba[1]);

   // Reference model: plain arrays of register values and busy flags
   logic [31:0] m_reg  [2][32];
   bit          m_busy [2][32];

   exp_t exp_q [$];
   int   errors = 0;
   int   checks = 0;

   function automatic int depth(int inst);
      return (inst == 0) ? 32 : 8;
   endfunction

   function automatic int nrd(int inst);
      return (inst == 0) ? 2 : 3;
   endfunction

   function automatic logic [31:0] dmask(int inst);
      return (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 32; r++) begin
            m_reg[k][r]  = '0;
            m_busy[k][r] = 1'b0;
         end
   endfunction

   // Expected outputs for the currently driven inputs and current model state
   function automatic void push_all();
      exp_t e;
      int   cnt;
      for (int k = 0; k < 2; k++) begin
         for (int p = 0; p < nrd(k); p++) begin
            int a = s_ra[k][p];
            bit byp = s_we[k] && (s_wa[k] == a);
            e.inst = k; e.port = p;
            e.kind = 0;
            e.exp  = (a == 0) ? 32'h0 : (byp ? (s_wd[k] & dmask(k)) : m_reg[k][a]);
            exp_q.push_back(e);
            e.kind = 1;
            e.exp  = 32'((a != 0) && !byp && m_busy[k][a]);
            exp_q.push_back(e);
         end
         cnt = 0;
         for (int r = 0; r < depth(k); r++) cnt += int'(m_busy[k][r]);
         e.kind = 2; e.port = 0; e.exp = 32'(cnt);
         exp_q.push_back(e);
      end
   endfunction

   // Apply the clock-edge rules to the model
   function automatic void model_edge();
      for (int k = 0; k < 2; k++) begin
         if (s_we[k] && s_wa[k] != 0) m_reg[k][s_wa[k]] = s_wd[k] & dmask(k);
         if (s_we[k]) m_busy[k][s_wa[k]] = 1'b0;
         if (s_bs[k] && s_ba[k] != 0) m_busy[k][s_ba[k]] = 1'b1;
      end
   endfunction

   function automatic void idle(int k);
      s_we[k] = 1'b0; s_wa[k] = 0; s_wd[k] = '0;
      s_bs[k] = 1'b0; s_ba[k] = 0;
      for (int p = 0; p < 4; p++) s_ra[k][p] = 0;
   endfunction

   // One cycle: queue expectations, take the edge, update the model
   task automatic step();
      push_all();
      @(posedge clk);
      if (!rst) model_edge();
      #1;
   endtask

   // Monitor: compare every queued expectation at the falling edge
   always @(negedge clk) begin
      while (exp_q.size() > 0) begin
         exp_t        e;
         logic [31:0] act;
         e = exp_q.pop_front();
         case (e.kind)
            0: act = (e.inst == 0) ? bif.rd_data[e.port*32 +: 32]
                                   : 32'(sif.rd_data[e.port*16 +: 16]);
            1: act = (e.inst == 0) ? 32'(bif.rd_busy[e.port]) : 32'(sif.rd_busy[e.port]);
            default: act = (e.inst == 0) ? 32'(bif.busy_cnt) : 32'(sif.busy_cnt);
         endcase
         checks++;
         if (act !== e.exp) begin
            errors++;
            $display("FAIL inst%0d %s port%0d at %0t: got 0x%08h expected 0x%08h",
                     e.inst, (e.kind == 0) ? "rd_data" : (e.kind == 1) ? "rd_busy" : "busy_cnt",
                     e.port, $time, act, e.exp);
         end
      end
   end

   task automatic rand_cycle();
      for (int k = 0; k < 2; k++) begin
         int dm = depth(k) - 1;
         s_we[k] = 1'($urandom_range(0, 1));
         s_wa[k] = int'($urandom_range(0, dm));
         s_wd[k] = $urandom;
         s_bs[k] = 1'($urandom_range(0, 1));
         s_ba[k] = ($urandom_range(0, 3) == 0) ? s_wa[k] : int'($urandom_range(0, dm));
         for (int p = 0; p < 4; p++)
            s_ra[k][p] = ($urandom_range(0, 3) == 0) ? s_wa[k] : int'($urandom_range(0, dm));
      end
      step();
   endtask

   initial begin
      idle(0); idle(1);
      model_clear();
      @(posedge clk); #1;
      // Reset state
      s_ra[0][0] = 5; s_ra[0][1] = 9; s_ra[1][0] = 1; s_ra[1][1] = 2; s_ra[1][2] = 7;
      step();
      rst = 1'b0;
      idle(0); idle(1);

      // Random warm-up leaves data and busy bits behind
      for (int n = 0; n < 40; n++) rand_cycle();

      // Asynchronous reset pulse between edges
      idle(0); idle(1);
      s_ra[0][0] = 5; s_ra[0][1] = 3; s_ra[1][0] = 2; s_ra[1][1] = 4; s_ra[1][2] = 6;
      rst = 1'b1;
      model_clear();
      push_all();
      @(negedge clk); #2;
      rst = 1'b0;
      @(posedge clk); model_edge(); #1;
      idle(0); idle(1);

      // Write r5 then read on both ports
      s_we[0] = 1; s_wa[0] = 5; s_wd[0] = 32'hDEAD_BEEF; step(); idle(0);
      s_ra[0][0] = 5; s_ra[0][1] = 5; step(); idle(0);
      // Write to r0 is dropped
      s_we[0] = 1; s_wa[0] = 0; s_wd[0] = 32'h1234_5678; step(); idle(0);
      step();

      // Bypass with r7 stored 1 and busy
      s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 32'h1; step(); idle(0);
      s_bs[0] = 1; s_ba[0] = 7; step(); idle(0);
      s_ra[0][0] = 7; s_ra[0][1] = 7; step();
      s_we[0] = 1; s_wa[0] = 7; s_wd[0] = 32'hCAFE_F00D; step(); idle(0);

      // Scoreboard set/clear
      s_bs[0] = 1; s_ba[0] = 3; step(); idle(0);
      s_bs[0] = 1; s_ba[0] = 9; s_ra[0][0] = 3; step(); idle(0);
      s_ra[0][0] = 3; step();
      s_we[0] = 1; s_wa[0] = 3; s_wd[0] = 32'h33; step(); idle(0);
      s_ra[0][0] = 3; step(); idle(0);

      // Simultaneous set and clear on r4, then set on r0
      s_bs[0] = 1; s_ba[0] = 4; step(); idle(0);
      s_bs[0] = 1; s_ba[0] = 4; s_we[0] = 1; s_wa[0] = 4; s_wd[0] = 32'h44; step(); idle(0);
      s_ra[0][0] = 4; step(); idle(0);
      s_bs[0] = 1; s_ba[0] = 0; step(); idle(0);
      s_ra[0][0] = 4; step(); idle(0);

      // Sweep instance: fill all seven busy bits then drain with one extra clear
      for (int r = 1; r < 8; r++) begin
         s_bs[1] = 1; s_ba[1] = r; s_ra[1][0] = r; step();
      end
      idle(1);
      s_bs[1] = 1; s_ba[1] = 5; step(); idle(1);
      for (int r = 1; r < 8; r++) begin
         s_we[1] = 1; s_wa[1] = r; s_wd[1] = 32'(r * 32'h1111); s_ra[1][1] = r; step();
      end
      s_we[1] = 1; s_wa[1] = 3; s_wd[1] = 32'hBEEF; step(); idle(1);
      s_ra[1][0] = 3; s_ra[1][1] = 7; s_ra[1][2] = 1; step(); idle(1);

      // Random traffic on both instances
      for (int n = 0; n < 300; n++) rand_cycle();

      idle(0); idle(1);
      step();
      @(negedge clk); #1;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_reg_file_bp

// File: doc/reg_file_bp.md
# reg_file_bp

Parametrised, clocked successor to the single-cycle register file, intended for the pipelined core. It holds 2^ADDR_W general registers with register 0 hard-wired to zero, provides NUM_RD combinational read ports with same-cycle write-to-read bypass, and keeps a per-register busy scoreboard. The issue stage sets busy on a destination register; writeback clears it. Decode uses the busy bits for hazard stalls.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2^ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous and active-high
- we  in  1  write enable (writeback)
- wr_addr  in  ADDR_W  write register index
- wr_data  in  DATA_W  write data
- rd_addr  in  NUM_RD*ADDR_W  read indices; port i is bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port i is bits [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  busy bit of each read port's register
- busy_set  in  1  issue stage marks busy_addr as having an in-flight producer
- busy_addr  in  ADDR_W  register to mark busy
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- **Reset.** While rst is high, all registers are 0, all busy bits are 0, and busy_cnt is 0. Outputs then follow from this state: rd_data is 0 and rd_busy is 0 unless the bypass applies.
- **Write.** At a rising edge with we=1 and wr_addr≠0, wr_data is stored. A write with wr_addr=0 is ignored.
- **Read port i.** rd_data is computed as follows:
  - if rd_addr==0, the result is 0;
  - else if we=1 and wr_addr==rd_addr, the result is wr_data (bypass in the same cycle);
  - otherwise the result is the stored register value.
- **rd_busy[i].** This bit equals the stored busy bit, except:
  - it is 0 if rd_addr==0;
  - it is 0 if we=1 and wr_addr==rd_addr, because the bypass resolves the hazard in that cycle.
- **Busy update per register r at each edge:**
  - set wins: if busy_set && busy_addr==r && r≠0, busy[r] becomes 1, even if a clear of r happens in the same cycle (a new producer supersedes the old one);
  - else if we && wr_addr==r, busy[r] becomes 0;
  - else busy[r] is held.
- **Register 0.** busy[0] is never set.
- **busy_cnt.** Registered population count of busy bits. The next-state count is current + set_effective − clear_effective, where:
  - set_effective = the set targets a nonzero register that is not already busy;
  - clear_effective = the clear targets a busy register that is not simultaneously being set.
  - The count never underflows or overflows. Its range is 0..2^ADDR_W−1.
- **Redundant operations.**
  - Setting a register that is already busy leaves it busy and does not change the count.
  - Clearing a register that is not busy has no effect on busy or busy_cnt, but the data write still occurs.

## Timing
- **Writes.** Data becomes visible from storage one cycle after the write edge. In the write cycle itself it is visible through the bypass, so the effective read-after-write latency is 0.
- **Read path.** rd_data and rd_busy are combinational from rd_addr, we, wr_addr, wr_data and state. No register sits in the read path.
- **Busy bits.** busy_set takes effect in the stored busy bit on the next edge; there is no bypass of busy_set into rd_busy.
- **Counter.** busy_cnt is registered and is consistent with the busy bits after every edge.
- **Reset mid-operation.** Asserting rst clears all state immediately, without waiting for an edge. After rst deasserts, the first edge proceeds normally.

## Structure
- **Shared package/header:** DATA_W and ADDR_W defaults, plus the ZERO_REG index constant (0). These are shared with decode and hazard logic.
- **Sub-module reg_scoreboard:** contains the busy bits, the set/clear priority logic and busy_cnt. It takes busy_set, busy_addr, we and wr_addr, and exports the busy vector and the count.
- **Top level:** holds the storage array, the NUM_RD read-mux/bypass instances (generate loop), and the rd_busy qualification.

## Test plan
- **Reset.** Pulse rst asynchronously between edges, after prior writes. Required: all rd_data read back 0x00000000, rd_busy=0 and busy_cnt=0 immediately, before the next clock edge.
- **Write/read and register 0.** Write 0xDEADBEEF to r5, then read r5 on both ports on the next cycle. Required: 0xDEADBEEF. Then write 0x12345678 to r0. Required: r0 still reads 0.
- **Bypass.** Set rd_addr0=7 and drive we=1, wr_addr=7, wr_data=0xCAFEF00D in the same cycle, where stored r7=0x1. Required: rd_data0=0xCAFEF00D in that cycle, and rd_busy0=0 even if busy[7]=1.
- **Scoreboard.** Set busy on r3 and then on r9. Required: busy_cnt goes 1 then 2, and reading r3 gives rd_busy=1. Then write r3. Required: busy_cnt=1 and rd_busy(r3)=0.
- **Simultaneous set and clear.** With busy[4]=1, apply busy_set on r4 together with we on r4. Required: busy[4] stays 1 and busy_cnt is unchanged. Then busy_set on r0. Required: no change to busy bits or busy_cnt.
- **Parameter sweep.** Use NUM_RD=3, ADDR_W=3, DATA_W=16. Set busy on all 7 nonzero registers. Required: busy_cnt=7. Then clear all 7. Required: busy_cnt=0 with no underflow, including one extra clear of a register that is not busy.
